// File: rtl/cuckoo_hash_gen.sv
// Cuckoo-hash insert front end: takes a 32-bit key and hashes it one byte per cycle
// into two distinct 5-bit bucket indices, presented over a valid/ready handshake.
module cuckoo_hash_gen #(
    parameter logic [15:0] ACC1_INIT = 16'h1505,
    parameter logic [15:0] ACC2_INIT = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] num,
    output logic [4:0]  index1,
    output logic [4:0]  index2
);
    localparam int unsigned KEY_W  = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ACC_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, HASH, OUT} state_t;

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last_byte;
    logic [ACC_W-1:0]   acc1;
    logic [ACC_W-1:0]   acc2;
    logic [1:0]         bcnt;
    logic [BYTE_W-1:0]  byte_sel;
    logic [ACC_W-1:0]   acc1_step;
    logic [ACC_W-1:0]   acc2_step;
    logic [IDX_W-1:0]   fold1;
    logic [IDX_W-1:0]   fold2;
    logic [IDX_W-1:0]   idx2_step;

    // XOR-fold a 16-bit accumulator down to a 5-bit bucket index
    function automatic logic [IDX_W-1:0] fold(input logic [ACC_W-1:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10] ^ {4'b0000, a[15]};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign accept    = in_valid & in_ready;
    assign last_byte = (bcnt == 2'd3);

    // One hash round on the current byte, LSB first
    always_comb begin
        byte_sel  = num[{bcnt, 3'b000} +: BYTE_W];
        acc1_step = (ACC_W'(acc1 << 5) + acc1) ^ {8'h00, byte_sel};
        acc2_step = {acc2[12:0], acc2[15:13]} ^ {8'h00, byte_sel};
        fold1     = fold(acc1_step);
        fold2     = fold(acc2_step);
        // Force the second index away from the first so the insert stage never ping-pongs
        idx2_step = (fold2 != fold1) ? fold2 : (fold1 ^ IDX_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)    state_next = HASH;
            HASH:    if (last_byte) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num    <= '0;
            acc1   <= '0;
            acc2   <= '0;
            bcnt   <= '0;
            index1 <= '0;
            index2 <= '0;
        end else if (accept) begin
            num  <= key[KEY_W-1:0];
            acc1 <= ACC1_INIT;
            acc2 <= ACC2_INIT;
            bcnt <= '0;
        end else if (state == HASH) begin
            acc1 <= acc1_step;
            acc2 <= acc2_step;
            bcnt <= bcnt + 2'd1;
            if (last_byte) begin
                index1 <= fold1;
                index2 <= idx2_step;
            end
        end
    end
endmodule

// File: tb/tb_cuckoo_hash_gen.sv
// Directed bench for cuckoo_hash_gen: hand-computed vectors, back-pressure,
// reset mid-hash, streaming throughput and a model-checked key sweep.
module tb_cuckoo_hash_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] num;
    logic [4:0]  index1;
    logic [4:0]  index2;

    int errors = 0;
    int checks = 0;

    cuckoo_hash_gen dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .num(num), .index1(index1), .index2(index2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] fold_m(input logic [15:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10] ^ {4'b0000, a[15]};
    endfunction

    // Reference hash: returns {index1, index2}
    function automatic logic [9:0] model(input logic [31:0] k);
        logic [15:0] a1;
        logic [15:0] a2;
        logic [7:0]  b;
        logic [4:0]  f1;
        logic [4:0]  f2;
        a1 = 16'h1505;
        a2 = 16'hACE1;
        for (int i = 0; i < 4; i++) begin
            b  = k[8*i +: 8];
            a1 = 16'(a1 * 16'd33) ^ {8'h00, b};
            a2 = ((a2 << 3) | (a2 >> 13)) ^ {8'h00, b};
        end
        f1 = fold_m(a1);
        f2 = fold_m(a2);
        if (f2 == f1) f2 = f1 ^ 5'd1;
        return {f1, f2};
    endfunction

    task automatic send_key(input logic [31:0] k);
        int n;
        n = 0;
        @(negedge clk);
        key      = k;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) check("out_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        int          sent;
        int          seen;
        int          take;
        int          last_t;
        int          collisions;
        logic [31:0] keys [3];
        logic [31:0] rk;
        logic [9:0]  exp_idx;

        keys[0] = 32'h0000_0000;
        keys[1] = 32'h0000_0001;
        keys[2] = 32'h1234_5678;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_outputs",   64'({num, index1, index2}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Key 0: latency, indices and final accumulators
        send_key(32'h0000_0000);
        wait_out(lat);
        check("k0_latency", 64'(lat), 64'd4);
        check("k0_num",     64'(num), 64'd0);
        check("k0_index1",  64'(index1), 64'd26);
        check("k0_index2",  64'(index2), 64'd30);
        check("k0_acc1",    64'(dut.acc1), 64'h0F85);
        check("k0_acc2",    64'(dut.acc2), 64'h1ACE);
        consume();
        check("k0_in_ready_after", 64'(in_ready), 64'd1);
        check("k0_out_valid_after", 64'(out_valid), 64'd0);

        // Key 1 under back-pressure with a competing key offered
        send_key(32'h0000_0001);
        wait_out(lat);
        check("k1_latency", 64'(lat), 64'd4);
        check("k1_acc1",    64'(dut.acc1), 64'h8324);
        check("k1_acc2",    64'(dut.acc2), 64'h18CE);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            key      = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            check("bp_hold", 64'({out_valid, num, index1, index2}),
                  64'({1'b1, 32'h0000_0001, 5'd28, 5'd14}));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        consume();
        check("bp_release", 64'({in_ready, out_valid}), 64'b10);

        // Reset two edges into hashing: no output, straight back to IDLE
        send_key(32'h0000_0001);
        @(posedge clk);
        #1;
        check("rst_pre_valid", 64'(out_valid), 64'd0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_num", 64'(num), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_output", 64'({in_ready, out_valid}), 64'b10);
        send_key(32'h0000_0000);
        wait_out(lat);
        check("rst_followup", 64'({num, index1, index2}), 64'({32'h0, 5'd26, 5'd30}));
        consume();

        // Streaming: in_valid and out_ready held high
        sent = 0; seen = 0; last_t = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            in_valid = (sent < 3);
            key      = keys[(sent < 3) ? sent : 2];
            take     = int'(in_valid & in_ready);
            @(posedge clk);
            #1;
            if (take != 0) sent++;
            if (out_valid) begin
                if (seen < 3) begin
                    exp_idx = model(keys[seen]);
                    check("stream_result", 64'({num, index1, index2}), 64'({keys[seen], exp_idx}));
                    if (seen > 0) check("stream_spacing", 64'(cyc - last_t), 64'd6);
                end
                last_t = cyc;
                seen++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 64'(seen), 64'd3);

        // Model sweep over varied keys
        collisions = 0;
        for (int n = 0; n < 300; n++) begin
            rk = (n < 4) ? (32'h0000_00FF << (8 * n)) : $urandom;
            send_key(rk);
            wait_out(lat);
            exp_idx = model(rk);
            check("sweep_result", 64'({num, index1, index2}), 64'({rk, exp_idx}));
            check("sweep_distinct", 64'(index1 != index2), 64'd1);
            if (fold_m(dut.acc1) == fold_m(dut.acc2)) begin
                collisions++;
                check("sweep_collision", 64'(index2), 64'(index1 ^ 5'd1));
            end
            consume();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
